// File: rtl/cb_heep_obi2reg_pkg.sv
// -----------------------------------------------------------------------------
// cb_heep_obi2reg_pkg
// Shared types for the OBI -> register-interface bridge:
//   state_t       : bridge FSM states (IDLE, REQ, RESP)
//   TIMEOUT_RDATA : read data returned when an access is aborted by the
//                   optional timeout (CB_HEEP_OBI2REG_TIMEOUT_EN)
//   req_cap_t     : the OBI request as captured at grant time
// The capture struct is sized for the CB-heep 32-bit address/data bus.
// -----------------------------------------------------------------------------
package cb_heep_obi2reg_pkg;

  localparam int OBI_AW = 32;
  localparam int OBI_DW = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [31:0] TIMEOUT_RDATA = 32'hBADCAB1E;

  typedef struct packed {
    logic                  we;
    logic [OBI_DW/8-1:0]   be;
    logic [OBI_AW-1:0]     addr;
    logic [OBI_DW-1:0]     wdata;
  } req_cap_t;

endpackage

// File: rtl/cb_heep_obi2reg_bridge.sv
// -----------------------------------------------------------------------------
// cb_heep_obi2reg_bridge
// Single-outstanding bridge from an OBI slave port to the register-interface
// request/response used by the CB-heep control register file.
//
// Handshakes: an OBI request is accepted when obi_req_i && obi_gnt_o at a
// rising clk_i; a register access completes when reg_valid_o && reg_ready_i at
// a rising clk_i; the OBI response is the single cycle with obi_rvalid_o high.
//
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   obi_req_i/obi_gnt_o   OBI request / grant (grant only in IDLE)
//   obi_we_i, obi_be_i, obi_addr_i, obi_wdata_i   OBI request payload
//   obi_rvalid_o, obi_rdata_o, obi_err_o          OBI response beat
//   reg_valid_o, reg_write_o, reg_addr_o, reg_wdata_o, reg_wstrb_o
//                         register request (held stable until reg_ready_i)
//   reg_ready_i, reg_rdata_i, reg_error_i         register completion
//   dbg_state_o           current FSM state, for observation only
//
// Optional feature macro: CB_HEEP_OBI2REG_TIMEOUT_EN
//   When defined, an access waiting TIMEOUT_CYCLES cycles in REQ without
//   reg_ready_i is aborted with an error response carrying TIMEOUT_RDATA.
// -----------------------------------------------------------------------------
module cb_heep_obi2reg_bridge
  import cb_heep_obi2reg_pkg::*;
#(
  parameter int AW             = 32,
  parameter int DW             = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            obi_req_i,
  output logic            obi_gnt_o,
  input  logic            obi_we_i,
  input  logic [DW/8-1:0] obi_be_i,
  input  logic [AW-1:0]   obi_addr_i,
  input  logic [DW-1:0]   obi_wdata_i,
  output logic            obi_rvalid_o,
  output logic [DW-1:0]   obi_rdata_o,
  output logic            obi_err_o,
  output logic            reg_valid_o,
  output logic            reg_write_o,
  output logic [AW-1:0]   reg_addr_o,
  output logic [DW-1:0]   reg_wdata_o,
  output logic [DW/8-1:0] reg_wstrb_o,
  input  logic            reg_ready_i,
  input  logic [DW-1:0]   reg_rdata_i,
  input  logic            reg_error_i,
  output logic [1:0]      dbg_state_o
);

  // The capture struct lives in the package at fixed widths.
  if (AW != OBI_AW || DW != OBI_DW || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("cb_heep_obi2reg_bridge: unsupported AW/DW/TIMEOUT_CYCLES");
  end

  state_t        r_state;
  req_cap_t      r_cap;
  logic [DW-1:0] r_rdata;
  logic          r_err;

  logic w_idle;
  logic w_in_req;
  logic w_in_resp;

  assign w_idle    = (r_state == ST_IDLE);
  assign w_in_req  = (r_state == ST_REQ);
  assign w_in_resp = (r_state == ST_RESP);

`ifdef CB_HEEP_OBI2REG_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] r_cnt;
  logic          w_timeout;
  // Fires on the last allowed REQ cycle so reg_valid_o is high for exactly
  // TIMEOUT_CYCLES cycles before the abort.
  assign w_timeout = (r_cnt == CW'(TIMEOUT_CYCLES - 1));
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_cap   <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
`ifdef CB_HEEP_OBI2REG_TIMEOUT_EN
      r_cnt   <= '0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (obi_req_i) begin
            r_cap.we    <= obi_we_i;
            r_cap.be    <= obi_be_i;
            r_cap.addr  <= obi_addr_i;
            r_cap.wdata <= obi_wdata_i;
            r_state     <= ST_REQ;
`ifdef CB_HEEP_OBI2REG_TIMEOUT_EN
            r_cnt       <= '0;
`endif
          end
        end
        ST_REQ: begin
          // A completion arriving together with the timeout wins.
          if (reg_ready_i) begin
            r_err   <= reg_error_i;
            r_rdata <= r_cap.we ? '0 : reg_rdata_i;
            r_state <= ST_RESP;
          end
`ifdef CB_HEEP_OBI2REG_TIMEOUT_EN
          else if (w_timeout) begin
            r_err   <= 1'b1;
            r_rdata <= DW'(TIMEOUT_RDATA);
            r_state <= ST_RESP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
`endif
        end
        ST_RESP: begin
          r_rdata <= '0;
          r_err   <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Grant is combinational from the request while idle: the capture happens
  // on the same edge the handshake completes.
  assign obi_gnt_o    = w_idle & obi_req_i;

  assign reg_valid_o  = w_in_req;
  assign reg_write_o  = w_in_req & r_cap.we;
  // Register file is word-addressed; byte offset bits are dropped.
  assign reg_addr_o   = w_in_req ? (r_cap.addr & ~AW'(3)) : '0;
  assign reg_wdata_o  = w_in_req ? r_cap.wdata : '0;
  assign reg_wstrb_o  = (w_in_req && r_cap.we) ? r_cap.be : '0;

  assign obi_rvalid_o = w_in_resp;
  assign obi_rdata_o  = w_in_resp ? r_rdata : '0;
  assign obi_err_o    = w_in_resp & r_err;

  assign dbg_state_o  = r_state;

endmodule

// File: tb/tb_cb_heep_obi2reg_bridge.sv
// -----------------------------------------------------------------------------
// tb_cb_heep_obi2reg_bridge
// Self-checking bench for cb_heep_obi2reg_bridge. Inputs are driven and
// outputs sampled around the falling clock edge. The bench acts as OBI master
// and as register-file slave; expected responses are queued when the slave
// completes an access and popped when the bridge returns its response.
// Built with CB_HEEP_OBI2REG_TIMEOUT_EN defined, the timeout abort is checked;
// otherwise the bridge must still be waiting after 1000 cycles.
// -----------------------------------------------------------------------------
module tb_cb_heep_obi2reg_bridge;
  import cb_heep_obi2reg_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          obi_req;
  logic          obi_gnt_o;
  logic          obi_we;
  logic [BW-1:0] obi_be;
  logic [AW-1:0] obi_addr;
  logic [DW-1:0] obi_wdata;
  logic          obi_rvalid_o;
  logic [DW-1:0] obi_rdata_o;
  logic          obi_err_o;
  logic          reg_valid_o;
  logic          reg_write_o;
  logic [AW-1:0] reg_addr_o;
  logic [DW-1:0] reg_wdata_o;
  logic [BW-1:0] reg_wstrb_o;
  logic          reg_ready;
  logic [DW-1:0] reg_rdata;
  logic          reg_error;
  logic [1:0]    dbg_state_o;

  int n_total = 0;
  int n_bad   = 0;
  logic [DW:0] exp_q[$];   // {err, rdata}

  cb_heep_obi2reg_bridge #(
    .AW(AW), .DW(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .obi_req_i(obi_req), .obi_gnt_o(obi_gnt_o),
    .obi_we_i(obi_we), .obi_be_i(obi_be),
    .obi_addr_i(obi_addr), .obi_wdata_i(obi_wdata),
    .obi_rvalid_o(obi_rvalid_o), .obi_rdata_o(obi_rdata_o), .obi_err_o(obi_err_o),
    .reg_valid_o(reg_valid_o), .reg_write_o(reg_write_o),
    .reg_addr_o(reg_addr_o), .reg_wdata_o(reg_wdata_o), .reg_wstrb_o(reg_wstrb_o),
    .reg_ready_i(reg_ready), .reg_rdata_i(reg_rdata), .reg_error_i(reg_error),
    .dbg_state_o(dbg_state_o)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected test end");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checking ----------------
  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- drivers ----------------
  // One complete transaction; called at a falling edge with the bridge idle.
  task automatic run_txn(input logic we, input logic [BW-1:0] be,
                         input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                         input int delay, input logic [DW-1:0] s_rdata,
                         input logic s_err, input bit hold_req);
    logic [AW-1:0] exp_addr;
    logic [DW:0]   exp_resp;
    exp_addr  = addr - (addr % 4);
    obi_req   = 1'b1;
    obi_we    = we;
    obi_be    = be;
    obi_addr  = addr;
    obi_wdata = wdata;
    #1;
    check_val("gnt_idle", obi_gnt_o, 1'b1);
    check_val("valid_idle", reg_valid_o, 1'b0);
    @(negedge clk);
    // Request payload changes after the grant must not reach the register bus.
    if (!hold_req) obi_req = 1'b0;
    obi_we    = $urandom_range(0, 1);
    obi_be    = BW'($urandom);
    obi_addr  = $urandom;
    obi_wdata = $urandom;
    for (int i = 0; i <= delay; i++) begin
      if (i > 0) @(negedge clk);
      check_val("req_valid", reg_valid_o, 1'b1);
      check_val("req_write", reg_write_o, we);
      check_val("req_addr", reg_addr_o, exp_addr);
      check_val("req_wdata", reg_wdata_o, wdata);
      check_val("req_wstrb", reg_wstrb_o, we ? be : '0);
      check_val("req_gnt", obi_gnt_o, 1'b0);
      check_val("req_rvalid", obi_rvalid_o, 1'b0);
      if (i == delay) begin
        reg_ready = 1'b1;
        reg_rdata = s_rdata;
        reg_error = s_err;
        exp_q.push_back({s_err, we ? {DW{1'b0}} : s_rdata});
      end else begin
        reg_ready = 1'b0;
        reg_rdata = $urandom;
        reg_error = $urandom_range(0, 1);
      end
    end
    @(negedge clk);
    check_val("resp_rvalid", obi_rvalid_o, 1'b1);
    check_val("resp_valid", reg_valid_o, 1'b0);
    check_val("resp_gnt", obi_gnt_o, 1'b0);
    if (exp_q.size() == 0) begin
      check_val("resp_queue", 1'b0, 1'b1);
    end else begin
      exp_resp = exp_q.pop_front();
      check_val("resp_data", {obi_err_o, obi_rdata_o}, exp_resp);
    end
    // Register-side inputs outside REQ must be ignored.
    reg_ready = $urandom_range(0, 1);
    reg_rdata = $urandom;
    reg_error = $urandom_range(0, 1);
    obi_req   = 1'b0;
    @(negedge clk);
    check_val("post_rvalid", obi_rvalid_o, 1'b0);
    check_val("post_rdata", {obi_err_o, obi_rdata_o}, '0);
    check_val("post_valid", reg_valid_o, 1'b0);
    check_val("post_gnt", obi_gnt_o, 1'b0);
    reg_ready = 1'b0;
  endtask

  // Continuous requests with an always-ready slave: grants every 3rd cycle.
  task automatic run_back_to_back();
    int last = -1;
    int n_gnt = 0;
    obi_req   = 1'b1;
    obi_we    = 1'b0;
    obi_be    = '1;
    obi_addr  = 32'h2000_0008;
    reg_ready = 1'b1;
    reg_rdata = 32'h1234_5678;
    reg_error = 1'b0;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (obi_gnt_o) begin
        if (last >= 0) check_val("b2b_gap", 64'(c - last), 64'd3);
        last = c;
        n_gnt++;
      end
      check_val("b2b_rvalid", obi_rvalid_o, (c % 3) == 2);
      if (obi_rvalid_o) check_val("b2b_rdata", obi_rdata_o, 32'h1234_5678);
      @(negedge clk);
    end
    check_val("b2b_count", 64'(n_gnt), 64'd4);
    obi_req   = 1'b0;
    reg_ready = 1'b0;
    @(negedge clk);
  endtask

  // Asynchronous reset while the register access is outstanding.
  task automatic run_reset_mid_req();
    int n_rv = 0;
    obi_req  = 1'b1;
    obi_we   = 1'b0;
    obi_addr = 32'h2000_000C;
    reg_ready = 1'b0;
    @(negedge clk);
    obi_req = 1'b0;
    check_val("rst_pre_valid", reg_valid_o, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check_val("rst_async_valid", reg_valid_o, 1'b0);
    check_val("rst_async_addr", reg_addr_o, '0);
    @(negedge clk);
    rst       = 1'b0;
    reg_ready = 1'b1;
    reg_rdata = $urandom;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (obi_rvalid_o || reg_valid_o) n_rv++;
    end
    check_val("rst_no_rvalid", 64'(n_rv), 64'd0);
    reg_ready = 1'b0;
  endtask

  // Slave never answers.
  task automatic run_no_ready();
    int n_valid = 0;
    int n_rv = 0;
    obi_req   = 1'b1;
    obi_we    = 1'b0;
    obi_addr  = 32'h2000_0010;
    reg_ready = 1'b0;
    @(negedge clk);
    obi_req = 1'b0;
`ifdef CB_HEEP_OBI2REG_TIMEOUT_EN
    for (int i = 0; i < 20; i++) begin
      if (!reg_valid_o) break;
      n_valid++;
      @(negedge clk);
    end
    check_val("to_valid_cycles", 64'(n_valid), 64'(TO));
    check_val("to_rvalid", obi_rvalid_o, 1'b1);
    check_val("to_err", obi_err_o, 1'b1);
    check_val("to_rdata", obi_rdata_o, 32'hBADCAB1E);
    @(negedge clk);
    check_val("to_after", obi_rvalid_o, 1'b0);
`else
    for (int i = 0; i < 1000; i++) begin
      if (reg_valid_o) n_valid++;
      if (obi_rvalid_o) n_rv++;
      @(negedge clk);
    end
    check_val("wait_valid_cycles", 64'(n_valid), 64'd1000);
    check_val("wait_no_rvalid", 64'(n_rv), 64'd0);
    check_val("wait_still_valid", reg_valid_o, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
`endif
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst       = 1'b1;
    obi_req   = 1'b0;
    obi_we    = 1'b0;
    obi_be    = '0;
    obi_addr  = '0;
    obi_wdata = '0;
    reg_ready = 1'b0;
    reg_rdata = '0;
    reg_error = 1'b0;
    #1;
    check_val("rst_state", dbg_state_o, ST_IDLE);
    check_val("rst_gnt", obi_gnt_o, 1'b0);
    check_val("rst_rvalid", obi_rvalid_o, 1'b0);
    check_val("rst_resp", {obi_err_o, obi_rdata_o}, '0);
    check_val("rst_reg", {reg_valid_o, reg_write_o, reg_addr_o, reg_wdata_o, reg_wstrb_o}, '0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_txn(1'b0, 4'hF, 32'h2000_0004, 32'h0, 0, 32'hCAFE_0001, 1'b0, 1'b0);
    run_txn(1'b1, 4'hF, 32'h2000_0000, 32'h1, 5, 32'hDEAD_BEEF, 1'b0, 1'b1);
    run_txn(1'b0, 4'hF, 32'h2000_0008, 32'h0, 1, 32'h5555_AAAA, 1'b1, 1'b0);
    run_txn(1'b0, 4'h3, 32'h2000_0007, 32'h0, 2, 32'h0BAD_F00D, 1'b0, 1'b0);
    run_txn(1'b1, 4'h0, 32'h2000_0014, 32'hFFFF_0000, 0, 32'h1, 1'b0, 1'b0);
    run_back_to_back();
    run_reset_mid_req();
    run_txn(1'b1, 4'h5, 32'h2000_0020, 32'hA5A5_5A5A, 1, 32'h0, 1'b1, 1'b0);

    for (int k = 0; k < 25; k++) begin
      run_txn($urandom_range(0, 1), BW'($urandom_range(0, 15)), $urandom, $urandom,
              $urandom_range(0, 3), $urandom, $urandom_range(0, 1), $urandom_range(0, 1));
    end

    run_no_ready();
    run_txn(1'b0, 4'hF, 32'h2000_0030, 32'h0, 0, 32'h7777_1111, 1'b0, 1'b0);

    check_val("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/cb_heep_obi2reg_bridge.md
Name: cb_heep_obi2reg_bridge

Overview:
Single-outstanding bridge from a core-side OBI slave port to the register-interface request/response used by the CB-heep control register file (cb_heep_ctrl and its siblings).
- Sits directly upstream of the control block and drives its register-request input from its register-side master port.
- Registers each OBI request, holds it on the register bus until ready, then returns exactly one OBI response beat.
- Decouples OBI grant/rvalid timing from the register-interface valid/ready handshake.

Parameters:
AW, 32, address width on both sides
DW, 32, data width on both sides (multiple of 8)
TIMEOUT_CYCLES, 255, cycles in REQ without reg_ready_i before abort (used only with the optional feature)

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
obi_req_i  in  1  OBI request
obi_gnt_o  out  1  OBI grant
obi_we_i  in  1  write enable
obi_be_i  in  DW/8  byte enables
obi_addr_i  in  AW  byte address
obi_wdata_i  in  DW  write data
obi_rvalid_o  out  1  response valid
obi_rdata_o  out  DW  read data
obi_err_o  out  1  response error
reg_valid_o  out  1  register request valid
reg_write_o  out  1  register write
reg_addr_o  out  AW  register address
reg_wdata_o  out  DW  register write data
reg_wstrb_o  out  DW/8  register write strobes
reg_ready_i  in  1  register access complete
reg_rdata_i  in  DW  register read data
reg_error_i  in  1  register access error

Behaviour:
- One clock (clk_i). Reset rst_i is asynchronous and active-high.
- Reset: FSM=IDLE. Every output and every internal capture register clears to 0.
- FSM states: IDLE, REQ, RESP.
- IDLE:
  - obi_gnt_o = obi_req_i (combinational); no other outputs asserted.
  - On req&&gnt: capture we, be, addr, wdata; go to REQ.
- REQ:
  - reg_valid_o=1.
  - reg_addr_o = captured addr with bits [1:0] forced to 0.
  - reg_write_o = captured we.
  - reg_wdata_o = captured wdata.
  - reg_wstrb_o = captured be when write, all-zero when read.
  - All reg_* fields stay stable until reg_ready_i.
  - obi_gnt_o=0.
  - On reg_ready_i: capture err=reg_error_i; rdata=reg_rdata_i for reads, 0 for writes; go to RESP.
- RESP:
  - obi_rvalid_o=1 for exactly one cycle, with captured rdata/err.
  - reg_valid_o=0, obi_gnt_o=0.
  - Next state IDLE.
- Latency:
  - Grant in cycle N.
  - reg_valid_o first high in N+1.
  - If reg_ready_i is high in N+1, obi_rvalid_o is high in N+2.
  - Best-case throughput: one transaction per 3 cycles.
- obi_rdata_o and obi_err_o are 0 whenever obi_rvalid_o=0.
- reg_ready_i, reg_rdata_i and reg_error_i are ignored outside REQ.
- obi_req_i deasserting after the grant has no effect on the transaction.
- Zero byte enables on a write are forwarded unchanged; the register file decides the outcome.
- Reset mid-transaction (any state): immediate return to IDLE; no rvalid is ever issued for the aborted access.

Optional Feature:
CB_HEEP_OBI2REG_TIMEOUT_EN
- Defined:
  - A clog2(TIMEOUT_CYCLES+1)-bit counter clears on REQ entry and increments each REQ cycle without reg_ready_i.
  - When the count equals TIMEOUT_CYCLES with reg_ready_i still low: drop reg_valid_o, go to RESP with obi_err_o=1 and obi_rdata_o=32'hBADCAB1E (truncated/zero-extended to DW).
  - reg_ready_i arriving in that same cycle wins over the timeout.
- Undefined:
  - No counter; REQ waits indefinitely.

Decomposition:
- Package cb_heep_obi2reg_pkg holds:
  - the state enum typedef;
  - TIMEOUT_RDATA constant (32'hBADCAB1E);
  - a packed request-capture struct {we, be, addr, wdata}.
- No sub-module; the timeout counter stays inline under the macro.

Test Plan:
- Read: addr 0x20000004, reg_ready_i high the first REQ cycle, reg_rdata_i=0xCAFE0001 -> reg_addr_o=0x20000004, wstrb=0; rvalid two cycles after grant with rdata 0xCAFE0001, err 0.
- Write: addr 0x20000000, wdata 0x1, be 0xF, ready delayed 5 cycles -> reg_* stable for 6 cycles; rvalid one cycle after ready with rdata 0, err 0; no grant during this time.
- Error: read with reg_error_i=1 at ready -> obi_err_o=1 with rvalid; back-to-back requests -> grants exactly 3 cycles apart.
- Misaligned address 0x20000007 -> reg_addr_o=0x20000004.
- Reset asserted asynchronously while in REQ -> reg_valid_o falls without a clock edge; no rvalid follows; next request completes normally.
- With CB_HEEP_OBI2REG_TIMEOUT_EN, TIMEOUT_CYCLES=4, ready never asserted -> reg_valid_o high 4 cycles, then rvalid with err=1, rdata=0xBADCAB1E. Without the macro -> still waiting after 1000 cycles.
